// File: rtl/trees_stream_loader.sv
// trees_stream_loader
// Front-end stage in front of the `trees` inference core. It turns command and
// 64-bit data streams into the core's node/feature write strobes. It also issues
// `start`, waits for `done`, and returns the prediction on a result stream.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op[1:0], cmd_len[31:0]     0=LOAD_TREES 1=LOAD_FEATURES 2=RUN 3=illegal; beat count
//   in_valid/in_ready, in_data     64-bit data beats
//   load_trees, n_tree, n_node,    node write strobe with its address and data
//   tree_nodes
//   load_features, n_feature,      feature-pair write strobe (n_feature is always even)
//   features2
//   start, done, prediction        core run control and result
//   res_valid/res_ready,           result handshake; res_err=1 flags a timeout
//   res_data, res_err              (res_data is 0 in that case)
//   busy                           state is not IDLE
//   cmd_err                        sticky flag for an illegal op or a clipped length
module trees_stream_loader #(
    parameter int N_TREES      = 128,
    parameter int N_NODES      = 256,
    parameter int N_FEATURE    = 32,
    parameter int DONE_HOLDOFF = 2,
    parameter int TIMEOUT      = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [31:0]                  cmd_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [63:0]                  in_data,
    output logic                         load_trees,
    output logic [$clog2(N_TREES)-1:0]   n_tree,
    output logic [$clog2(N_NODES)-1:0]   n_node,
    output logic [63:0]                  tree_nodes,
    output logic                         load_features,
    output logic [31:0]                  n_feature,
    output logic [63:0]                  features2,
    output logic                         start,
    input  logic [31:0]                  prediction,
    input  logic                         done,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [31:0]                  res_data,
    output logic                         res_err,
    output logic                         busy,
    output logic                         cmd_err
);

    localparam int TREE_W = $clog2(N_TREES);
    localparam int NODE_W = $clog2(N_NODES);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [31:0]       TREE_BEATS = 32'(N_TREES * N_NODES);
    localparam logic [31:0]       FEAT_BEATS = 32'(N_FEATURE / 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] HOLDOFF    = WAIT_W'(DONE_HOLDOFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TREES,
        S_FEATS,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]       len_reg;      // effective (clipped) beat count
    logic [31:0]       cnt_reg;      // beats accepted so far
    logic [WAIT_W-1:0] wait_reg;     // cycles spent in WAIT
    logic              load_trees_reg, load_features_reg;
    logic [TREE_W-1:0] n_tree_reg;
    logic [NODE_W-1:0] n_node_reg;
    logic [63:0]       tree_nodes_reg, features2_reg;
    logic [31:0]       n_feature_reg;
    logic [31:0]       res_data_reg;
    logic              res_err_reg, cmd_err_reg;

    logic cmd_fire, beat_fire, last_beat, loading, done_hit, timeout_hit;
    logic clip_trees, clip_feats;

    assign cmd_ready   = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign loading     = (state_reg == S_TREES) || (state_reg == S_FEATS);
    assign in_ready    = loading && (cnt_reg < len_reg);
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign beat_fire   = in_valid && in_ready;
    assign last_beat   = beat_fire && ((cnt_reg + 32'd1) == len_reg);
    // A done seen during the holdoff window is a leftover from the previous run.
    assign done_hit    = (state_reg == S_WAIT) && done && (wait_reg >= HOLDOFF);
    assign timeout_hit = (state_reg == S_WAIT) && !done_hit && (wait_reg == WAIT_LAST);
    assign clip_trees  = (cmd_len > TREE_BEATS);
    assign clip_feats  = (cmd_len > FEAT_BEATS);

    assign start         = (state_reg == S_START);
    assign res_valid     = (state_reg == S_RESULT);
    assign load_trees    = load_trees_reg;
    assign load_features = load_features_reg;
    assign n_tree        = n_tree_reg;
    assign n_node        = n_node_reg;
    assign tree_nodes    = tree_nodes_reg;
    assign n_feature     = n_feature_reg;
    assign features2     = features2_reg;
    assign res_data      = res_data_reg;
    assign res_err       = res_err_reg;
    assign cmd_err       = cmd_err_reg;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        2'd0:    state_next = S_TREES;
                        2'd1:    state_next = S_FEATS;
                        2'd2:    state_next = S_START;
                        default: state_next = S_IDLE;
                    endcase
                end
            end
            // Leave right after the last beat is taken; its strobe lands in IDLE.
            // The length check also covers zero-length commands.
            S_TREES, S_FEATS: begin
                if ((cnt_reg >= len_reg) || last_beat) state_next = S_IDLE;
            end
            S_START:  state_next = S_WAIT;
            S_WAIT: begin
                if (done_hit || timeout_hit) state_next = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg           <= '0;
            cnt_reg           <= '0;
            wait_reg          <= '0;
            load_trees_reg    <= 1'b0;
            load_features_reg <= 1'b0;
            n_tree_reg        <= '0;
            n_node_reg        <= '0;
            tree_nodes_reg    <= '0;
            n_feature_reg     <= '0;
            features2_reg     <= '0;
            res_data_reg      <= '0;
            res_err_reg       <= 1'b0;
            cmd_err_reg       <= 1'b0;
        end else begin
            load_trees_reg    <= 1'b0;
            load_features_reg <= 1'b0;

            if (cmd_fire) begin
                cnt_reg <= '0;
                case (cmd_op)
                    2'd0: begin
                        len_reg <= clip_trees ? TREE_BEATS : cmd_len;
                        if (clip_trees) cmd_err_reg <= 1'b1;
                    end
                    2'd1: begin
                        len_reg <= clip_feats ? FEAT_BEATS : cmd_len;
                        if (clip_feats) cmd_err_reg <= 1'b1;
                    end
                    2'd2:    len_reg <= '0;
                    default: cmd_err_reg <= 1'b1;
                endcase
            end

            if (beat_fire) begin
                cnt_reg <= cnt_reg + 32'd1;
                if (state_reg == S_TREES) begin
                    // The beat number splits directly into {tree, node}
                    // because N_NODES is a power of two.
                    load_trees_reg <= 1'b1;
                    tree_nodes_reg <= in_data;
                    n_tree_reg     <= cnt_reg[NODE_W +: TREE_W];
                    n_node_reg     <= cnt_reg[NODE_W-1:0];
                end else begin
                    load_features_reg <= 1'b1;
                    features2_reg     <= in_data;
                    n_feature_reg     <= {cnt_reg[30:0], 1'b0};
                end
            end

            if (state_reg == S_START) wait_reg <= '0;
            else if (state_reg == S_WAIT) wait_reg <= wait_reg + 1'b1;

            if (done_hit) begin
                res_data_reg <= prediction;
                res_err_reg  <= 1'b0;
            end else if (timeout_hit) begin
                res_data_reg <= '0;
                res_err_reg  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trees_stream_loader.sv
// Testbench for trees_stream_loader. Write strobes are checked against a
// queue of expected {cycle, kind, index, data} entries. An entry is pushed when
// a beat is handed over and popped when the strobe appears. Run results are
// checked the same way through a result queue.
module tb_trees_stream_loader;

    localparam int N_TREES   = 128;
    localparam int N_NODES   = 256;
    localparam int N_FEATURE = 32;
    localparam int TIMEOUT   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        load_trees;
    logic [6:0]  n_tree;
    logic [7:0]  n_node;
    logic [63:0] tree_nodes;
    logic        load_features;
    logic [31:0] n_feature;
    logic [63:0] features2;
    logic        start;
    logic [31:0] prediction;
    logic        done;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;
    logic        cmd_err;

    always #5 clk = ~clk;

    trees_stream_loader #(
        .N_TREES(N_TREES), .N_NODES(N_NODES), .N_FEATURE(N_FEATURE),
        .DONE_HOLDOFF(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .load_trees(load_trees), .n_tree(n_tree), .n_node(n_node), .tree_nodes(tree_nodes),
        .load_features(load_features), .n_feature(n_feature), .features2(features2),
        .start(start), .prediction(prediction), .done(done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy), .cmd_err(cmd_err)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;   // {load_trees, load_features}
        logic [31:0] idx;
        logic [63:0] data;
    } strobe_t;

    strobe_t     exp_q[$];
    logic [32:0] res_q[$];   // {err, data}

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int beat_k     = 0;
    int strobe_cnt = 0;
    int start_cnt  = 0;
    bit cur_trees  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int k, input int salt);
        return {32'(k) ^ 32'(salt << 20), 32'hA5A5_0000 ^ 32'(k * 3)};
    endfunction

    // Strobe scoreboard: pop and compare each visible strobe, then push the
    // expectation for a beat that the next edge will accept.
    always @(negedge clk) begin
        strobe_t e;
        strobe_t o;
        if (start) start_cnt++;
        if (load_trees || load_features) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", 160'({load_trees, load_features}), 160'd0);
            end else begin
                e      = exp_q.pop_front();
                o.cyc  = 32'(cyc);
                o.kind = {load_trees, load_features};
                o.idx  = load_trees ? {16'(n_tree), 16'(n_node)} : n_feature;
                o.data = load_trees ? tree_nodes : features2;
                chk("strobe", 160'(o), 160'(e));
            end
        end
        if (in_valid && in_ready && !rst) begin
            e.cyc  = 32'(cyc + 1);
            e.kind = cur_trees ? 2'b10 : 2'b01;
            e.idx  = cur_trees ? {16'(beat_k / N_NODES), 16'(beat_k % N_NODES)}
                               : 32'(2 * beat_k);
            e.data = in_data;
            exp_q.push_back(e);
            beat_k++;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] len);
        chk("cmd_ready_idle", 160'(cmd_ready), 160'd1);
        cur_trees = (op == 2'd0);
        beat_k    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic load_beats(input int n, input bit toggle, input int salt,
                              input int max_cycles, output int iters);
        iters = 0;
        while (beat_k < n && iters < max_cycles) begin
            in_valid = toggle ? (iters % 2 == 0) : 1'b1;
            in_data  = pat(beat_k, salt);
            step();
            iters++;
        end
        in_valid = 1'b0;
        chk("beats_accepted", 160'(beat_k), 160'(n));
    endtask

    // Core model. A non-stale run raises done only in cycle done_cyc, where
    // cycle 0 is the start pulse. A stale run keeps an old done high through
    // cycle 2. done_cyc == 0 means done never comes.
    task automatic run_core(input bit stale, input int done_cyc, input logic [31:0] pred,
                            input int exp_cyc);
        int          c;
        int          s0;
        bit          seen;
        logic [32:0] e;
        s0 = start_cnt;
        done       = stale;
        prediction = stale ? 32'd99 : 32'd0;
        if (done_cyc == 0) res_q.push_back({1'b1, 32'd0});
        send_cmd(2'd2, 32'd0);
        chk("start_pulse", 160'(start), 160'd1);
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 100) begin
            step();
            c++;
            if (res_valid) begin
                seen = 1'b1;
            end else if (stale && c <= 2) begin
                done = 1'b1; prediction = 32'd99;
            end else if (c == done_cyc) begin
                done = 1'b1; prediction = pred;
                res_q.push_back({1'b0, pred});
            end else begin
                done = 1'b0; prediction = 32'hDEAD_BEEF;
            end
        end
        done = 1'b0;
        chk("res_valid_seen", 160'(res_valid), 160'd1);
        chk("res_latency", 160'(c), 160'(exp_cyc));
        chk("start_count", 160'(start_cnt - s0), 160'd1);
        chk("res_queue", 160'(res_q.size()), 160'd1);
        if (res_q.size() > 0) begin
            e = res_q.pop_front();
            for (int h = 0; h < 3; h++) begin
                chk("res_valid_hold", 160'(res_valid), 160'd1);
                chk("res_data_hold", 160'(res_data), 160'(e[31:0]));
                chk("res_err_hold", 160'(res_err), 160'(e[32]));
                step();
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_drop", 160'(res_valid), 160'd0);
        chk("cmd_ready_after_run", 160'(cmd_ready), 160'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int it;
        int s0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; prediction = '0; done = 1'b0; res_ready = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_load_trees", 160'(load_trees), 160'd0);
        chk("rst_load_features", 160'(load_features), 160'd0);
        chk("rst_start", 160'(start), 160'd0);
        chk("rst_res_valid", 160'(res_valid), 160'd0);
        chk("rst_res_err", 160'(res_err), 160'd0);
        chk("rst_cmd_err", 160'(cmd_err), 160'd0);
        chk("rst_busy", 160'(busy), 160'd0);
        chk("rst_cmd_ready", 160'(cmd_ready), 160'd1);
        chk("rst_in_ready", 160'(in_ready), 160'd0);
        chk("rst_idx", 160'({n_tree, n_node, n_feature}), 160'd0);
        chk("rst_data", 160'({tree_nodes, features2, res_data}), 160'd0);
        rst = 1'b0;
        step();

        // Full tree load with no gaps
        s0 = strobe_cnt;
        send_cmd(2'd0, 32'd32768);
        load_beats(32768, 1'b0, 1, 40000, it);
        chk("trees_consecutive", 160'(it), 160'd32768);
        chk("trees_last_strobe", 160'(load_trees), 160'd1);
        chk("trees_last_idx", 160'({16'(n_tree), 16'(n_node)}), 160'({16'd127, 16'd255}));
        step();
        chk("trees_busy_after", 160'(busy), 160'd0);
        chk("trees_strobe_off", 160'(load_trees), 160'd0);
        chk("trees_strobe_count", 160'(strobe_cnt - s0), 160'd32768);
        chk("trees_queue_empty", 160'(exp_q.size()), 160'd0);

        // Feature load with toggling in_valid
        s0 = strobe_cnt;
        send_cmd(2'd1, 32'd16);
        load_beats(16, 1'b1, 2, 100, it);
        chk("feat_last_idx", 160'(n_feature), 160'd30);
        chk("feat_last_data", 160'(features2), 160'(pat(15, 2)));
        step();
        chk("feat_strobe_count", 160'(strobe_cnt - s0), 160'd16);
        chk("feat_queue_empty", 160'(exp_q.size()), 160'd0);
        chk("feat_busy_after", 160'(busy), 160'd0);

        // Zero-length load
        s0 = strobe_cnt;
        send_cmd(2'd0, 32'd0);
        in_valid = 1'b1;
        in_data  = pat(0, 3);
        chk("zero_in_ready", 160'(in_ready), 160'd0);
        step();
        chk("zero_busy", 160'(busy), 160'd0);
        in_valid = 1'b0;
        step();
        chk("zero_no_strobe", 160'(strobe_cnt - s0), 160'd0);
        chk("cmd_err_clean", 160'(cmd_err), 160'd0);

        // Runs: done at cycle 5 (-7); stale done then real done at cycle 4 (-123); timeout
        run_core(1'b0, 5, 32'hFFFF_FFF9, 6);
        run_core(1'b1, 4, 32'hFFFF_FF85, 5);
        run_core(1'b0, 0, 32'd0, TIMEOUT + 1);
        chk("cmd_err_after_runs", 160'(cmd_err), 160'd0);

        // Over-long feature load is clipped to 16 beats
        s0 = strobe_cnt;
        send_cmd(2'd1, 32'd40);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = pat(beat_k, 5);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("clip_beats", 160'(beat_k), 160'd16);
        chk("clip_strobes", 160'(strobe_cnt - s0), 160'd16);
        chk("clip_cmd_err", 160'(cmd_err), 160'd1);
        chk("clip_busy", 160'(busy), 160'd0);

        // Reset in the middle of a tree load
        send_cmd(2'd0, 32'd32768);
        load_beats(100, 1'b0, 7, 200, it);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = pat(100, 7);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("abort_load_trees", 160'(load_trees), 160'd0);
        chk("abort_busy", 160'(busy), 160'd0);
        chk("abort_cmd_ready", 160'(cmd_ready), 160'd1);
        chk("abort_cmd_err", 160'(cmd_err), 160'd0);
        chk("abort_queue_empty", 160'(exp_q.size()), 160'd0);
        step();
        chk("abort_no_strobe", 160'(load_trees), 160'd0);

        s0 = strobe_cnt;
        send_cmd(2'd0, 32'd3);
        load_beats(3, 1'b0, 9, 20, it);
        step();
        chk("restart_strobes", 160'(strobe_cnt - s0), 160'd3);
        chk("restart_queue_empty", 160'(exp_q.size()), 160'd0);

        // Illegal op
        send_cmd(2'd3, 32'd0);
        chk("illegal_cmd_err", 160'(cmd_err), 160'd1);
        chk("illegal_busy", 160'(busy), 160'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
